// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO.
// Contents:
//   DEFAULT_DEPTH  - default number of FIFO entries
//   DEFAULT_DATA_W - default byte width
//   tx_state_e     - transmit sequencer state encoding
//   lvl_w()        - width needed to hold a level of 0..depth
package uart_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } tx_state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART transmit FIFO.
// Synchronous write, combinational read; no reset on the array since
// every location is written before it can be read.
// Ports:
//   clk     - clock
//   wr_en   - write wr_data to wr_addr on this edge
//   wr_addr - write location
//   wr_data - byte to store
//   rd_addr - read location
//   rd_data - byte at rd_addr (combinational)
module uart_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a send/sent handshake.
// The head byte stays in the FIFO (and in level) while it is being sent
// and is popped only when the transmitter reports completion.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   wr_en     - push wr_data (dropped when full, which sets overflow)
//   wr_data   - byte to queue
//   flush     - discard queued bytes except the one in flight
//   enable    - allow new transmissions to start
//   clr_ovf   - clear the sticky overflow flag
//   tx_sent   - completion flag from the transmitter (rising edge = done)
//   tx_send   - start request to the transmitter
//   tx_data   - byte presented to the transmitter, stable during SEND
//   full      - level == DEPTH
//   empty     - level == 0
//   level     - queued bytes, including the one in flight
//   overflow  - sticky: a write was dropped
//   busy      - sequencer not idle
//
// state   | meaning
// IDLE    | waiting for enable and a queued byte
// SEND    | tx_send high, waiting for the rising edge of tx_sent
// RELEASE | byte popped, waiting for tx_sent to return low
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  input  logic                     enable,
  input  logic                     clr_ovf,
  input  logic                     tx_sent,
  output logic                     tx_send,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = lvl_w(DEPTH);

  tx_state_e         state, state_nx;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nx;
  logic [LW-1:0]     level_q;
  logic [DATA_W-1:0] head;
  logic              tx_sent_q;
  logic              done_edge;
  logic              push, pop, start, keep_head;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign busy      = (state != ST_IDLE);
  assign done_edge = tx_sent & ~tx_sent_q;

  // A write in the flush cycle is discarded, so it never reaches the array.
  assign push = wr_en & ~full & ~flush;

  always_comb begin
    state_nx = state;
    tx_send  = 1'b0;
    pop      = 1'b0;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !empty && !flush) begin
          start    = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_send = 1'b1;
        if (done_edge) begin
          pop      = 1'b1;
          state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!tx_sent) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rd_ptr_nx = pop ? rd_ptr + AW'(1) : rd_ptr;
  // During SEND the head byte is in flight and survives a flush unless it
  // completes in that same cycle.
  assign keep_head = (state == ST_SEND) && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      tx_data   <= '0;
      tx_sent_q <= 1'b0;
    end else begin
      state     <= state_nx;
      tx_sent_q <= tx_sent;

      if (start) begin
        tx_data <= head;
      end

      rd_ptr <= rd_ptr_nx;
      if (flush) begin
        wr_ptr  <= rd_ptr_nx + (keep_head ? AW'(1) : AW'(0));
        level_q <= keep_head ? LW'(1) : LW'(0);
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   level_q <= level_q + LW'(1);
          2'b01:   level_q <= level_q - LW'(1);
          default: level_q <= level_q;
        endcase
      end

      // Set has priority over clear.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  push wr_data this cycle.
REQ-006 SHALL have port wr_data  input  DATA_W  byte to queue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port enable  input  1  permit new transmissions to start.
REQ-009 SHALL have port clr_ovf  input  1  clear overflow flag.
REQ-010 SHALL have port tx_sent  input  1  completion flag from the UART transmitter.
REQ-011 SHALL have port tx_send  output  1  start request to the transmitter.
REQ-012 SHALL have port tx_data  output  DATA_W  byte presented to the transmitter.
REQ-013 SHALL have port full  output  1  level == DEPTH.
REQ-014 SHALL have port empty  output  1  level == 0.
REQ-015 SHALL have port level  output  clog2(DEPTH)+1  queued byte count, including the byte in flight.
REQ-016 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-017 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-018 SHALL implement a circular buffer with registered read/write pointers that wrap modulo DEPTH.
REQ-019 SHALL accept a write when wr_en=1 and full=0; the byte is visible in level on the next cycle.
REQ-020 SHALL drop a write when wr_en=1 and full=1 and set overflow on the next cycle, even if a pop occurs in the same cycle.
REQ-021 SHALL leave level unchanged on a simultaneous accepted write and pop, with both pointers advancing.
REQ-022 SHALL hold overflow until clr_ovf=1; if set and clear coincide, set wins.
REQ-023 SHALL register tx_sent into tx_sent_q; done_edge = tx_sent & ~tx_sent_q.
REQ-024 SHALL use FSM states IDLE, SEND, RELEASE.
REQ-025 SHALL, in IDLE: tx_send=0; if enable=1, empty=0 and flush=0, latch the head byte into tx_data and go to SEND.
REQ-026 SHALL, in SEND: tx_send=1 with tx_data stable; on done_edge, pop the head and go to RELEASE.
REQ-027 SHALL, in RELEASE: tx_send=0; go to IDLE once tx_sent=0.
REQ-028 SHALL add 2 cycles of latency from the first write into an empty FIFO to tx_send=1.
REQ-029 SHALL never pop on any condition other than done_edge in SEND.
REQ-030 SHALL, when enable drops during SEND, complete the current byte and start no further bytes.
REQ-031 SHALL, on flush, empty the FIFO next cycle except the in-flight byte, which pops normally; a write in the flush cycle is discarded.
REQ-032 SHALL compute level with width clog2(DEPTH)+1 so level=DEPTH is representable.

Reset
REQ-033 SHALL, on rst=1 at a clock edge: pointers=0, level=0, empty=1, full=0, overflow=0, tx_send=0, tx_data=0, busy=0, tx_sent_q=0, FSM=IDLE.
REQ-034 SHALL give rst priority over all inputs; reset mid-SEND drops tx_send on that edge and discards the in-flight byte.

Structure
REQ-035 SHALL take the FSM state encoding and DEFAULT_DEPTH constant from shared package uart_pkg.
REQ-036 SHALL use one sub-module, uart_fifo_mem (DEPTH x DATA_W register array, synchronous write, combinational read); the FSM and pointers stay in uart_tx_fifo.

Verification
REQ-037 SHALL cover single byte: write 0x5A to an empty FIFO with enable=1 -> tx_send=1 two cycles later, tx_data=0x5A; tx_sent pulse -> level 1->0; IDLE after tx_sent=0.
REQ-038 SHALL cover fill/overflow: 9 writes with enable=0, DEPTH=8 -> full=1, level=8, overflow=1; clr_ovf -> overflow=0; bytes later sent in order 1..8.
REQ-039 SHALL cover wrap: 20 bytes 0x00..0x13 streamed with an emulated transmitter -> all bytes out in order, no overflow, pointers wrap twice.
REQ-040 SHALL cover simultaneous write+pop at level=3 -> level stays 3.
REQ-041 SHALL cover flush during SEND of 0xA1 with 0xA2,0xA3 queued -> 0xA1 completes, then level=0 and no further tx_send.
REQ-042 SHALL cover reset mid-SEND -> tx_send=0, level=0, overflow=0 on that edge; tx_sent held high afterwards causes no pop.
